// File: rtl/bimodal_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Define BP_GSHARE_EN to XOR a global history register into the table index.
module bimodal_btb #(
    parameter int FETCH_W  = 3,
    parameter int UPD_W    = 2,
    parameter int DEPTH    = 16,
    parameter int TAG_BITS = 8,
    parameter int XLEN     = 32,
    localparam int IDX_BITS  = $clog2(DEPTH),
    localparam int LANE_BITS = (FETCH_W > 1) ? $clog2(FETCH_W) : 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [FETCH_W-1:0]            fetch_EN,
    input  logic [FETCH_W-1:0][XLEN-1:0]  fetch_pc,
    output logic [FETCH_W-1:0]            predict_direction,
    output logic [FETCH_W-1:0][XLEN-1:0]  predict_pc,
    output logic                          taken_any,
    output logic [LANE_BITS-1:0]          taken_idx,
    input  logic [UPD_W-1:0]              update_EN,
    input  logic [UPD_W-1:0][XLEN-1:0]    update_pc,
    input  logic [UPD_W-1:0]              update_direction,
    input  logic [UPD_W-1:0][XLEN-1:0]    update_target,
    input  logic                          flush_EN
);

    logic                valid_q  [DEPTH];
    logic [TAG_BITS-1:0] tag_q    [DEPTH];
    logic [1:0]          ctr_q    [DEPTH];
    logic [XLEN-1:0]     target_q [DEPTH];

    logic [IDX_BITS-1:0] hist;

`ifdef BP_GSHARE_EN
    logic [IDX_BITS-1:0] ghr_q, ghr_d;

    assign hist = ghr_q;

    // History shifts once per enabled port, lowest port first.
    always_comb begin
        ghr_d = ghr_q;
        for (int p = 0; p < UPD_W; p++) begin
            if (update_EN[p]) ghr_d = {ghr_d[IDX_BITS-2:0], update_direction[p]};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)        ghr_q <= '0;
        else if (flush_EN) ghr_q <= '0;
        else               ghr_q <= ghr_d;
    end
`else
    assign hist = '0;
`endif

    logic [FETCH_W-1:0][IDX_BITS-1:0] f_idx;
    logic [FETCH_W-1:0]               f_hit;

    always_comb begin
        for (int i = 0; i < FETCH_W; i++) begin
            f_idx[i] = fetch_pc[i][IDX_BITS+1:2] ^ hist;
            f_hit[i] = valid_q[f_idx[i]] &&
                       (tag_q[f_idx[i]] == fetch_pc[i][TAG_BITS+IDX_BITS+1:IDX_BITS+2]);
            predict_direction[i] = fetch_EN[i] && f_hit[i] && ctr_q[f_idx[i]][1];
            predict_pc[i] = predict_direction[i] ? target_q[f_idx[i]]
                                                 : fetch_pc[i] + XLEN'(4);
        end
    end

    always_comb begin
        taken_any = 1'b0;
        taken_idx = '0;
        for (int i = FETCH_W - 1; i >= 0; i--) begin
            if (predict_direction[i]) begin
                taken_any = 1'b1;
                taken_idx = LANE_BITS'(i);
            end
        end
    end

    logic [UPD_W-1:0][IDX_BITS-1:0] u_idx;
    logic [UPD_W-1:0][TAG_BITS-1:0] u_tag;
    logic [UPD_W-1:0]               u_hit;
    logic [UPD_W-1:0]               u_win;

    always_comb begin
        for (int p = 0; p < UPD_W; p++) begin
            u_idx[p] = update_pc[p][IDX_BITS+1:2] ^ hist;
            u_tag[p] = update_pc[p][TAG_BITS+IDX_BITS+1:IDX_BITS+2];
            u_hit[p] = valid_q[u_idx[p]] && (tag_q[u_idx[p]] == u_tag[p]);
        end
        // A port is dropped when any higher enabled port targets the same index.
        for (int p = 0; p < UPD_W; p++) begin
            u_win[p] = update_EN[p];
            for (int q = p + 1; q < UPD_W; q++) begin
                if (update_EN[q] && (u_idx[q] == u_idx[p])) u_win[p] = 1'b0;
            end
        end
    end

    logic unused_pc_bits;
    assign unused_pc_bits = ^update_pc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int d = 0; d < DEPTH; d++) begin
                valid_q[d]  <= 1'b0;
                tag_q[d]    <= '0;
                ctr_q[d]    <= 2'b01;
                target_q[d] <= '0;
            end
        end else if (flush_EN) begin
            for (int d = 0; d < DEPTH; d++) valid_q[d] <= 1'b0;
        end else begin
            for (int p = 0; p < UPD_W; p++) begin
                if (u_win[p]) begin
                    if (u_hit[p]) begin
                        if (update_direction[p]) begin
                            if (ctr_q[u_idx[p]] != 2'b11)
                                ctr_q[u_idx[p]] <= ctr_q[u_idx[p]] + 2'd1;
                            target_q[u_idx[p]] <= update_target[p];
                        end else if (ctr_q[u_idx[p]] != 2'b00) begin
                            ctr_q[u_idx[p]] <= ctr_q[u_idx[p]] - 2'd1;
                        end
                    end else if (update_direction[p]) begin
                        valid_q[u_idx[p]]  <= 1'b1;
                        tag_q[u_idx[p]]    <= u_tag[p];
                        ctr_q[u_idx[p]]    <= 2'b10;
                        target_q[u_idx[p]] <= update_target[p];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bimodal_btb.sv
// Bench for bimodal_btb: directed scenarios plus randomized traffic against a table model.
module tb_bimodal_btb;
    localparam int FW = 3;
    localparam int UW = 2;
    localparam int D  = 16;
    localparam int TB = 8;
    localparam int XL = 32;
    localparam int IB = 4;

    logic                   clock = 1'b0;
    logic                   reset;
    logic [FW-1:0]          fetch_EN;
    logic [FW-1:0][XL-1:0]  fetch_pc;
    logic [FW-1:0]          predict_direction;
    logic [FW-1:0][XL-1:0]  predict_pc;
    logic                   taken_any;
    logic [1:0]             taken_idx;
    logic [UW-1:0]          update_EN;
    logic [UW-1:0][XL-1:0]  update_pc;
    logic [UW-1:0]          update_direction;
    logic [UW-1:0][XL-1:0]  update_target;
    logic                   flush_EN;

    always #5 clock = ~clock;

    bimodal_btb #(.FETCH_W(FW), .UPD_W(UW), .DEPTH(D), .TAG_BITS(TB), .XLEN(XL)) dut (
        .clock(clock), .reset(reset),
        .fetch_EN(fetch_EN), .fetch_pc(fetch_pc),
        .predict_direction(predict_direction), .predict_pc(predict_pc),
        .taken_any(taken_any), .taken_idx(taken_idx),
        .update_EN(update_EN), .update_pc(update_pc),
        .update_direction(update_direction), .update_target(update_target),
        .flush_EN(flush_EN)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference table: plain per-entry fields, counter kept as an integer 0..3.
    bit          m_valid [D];
    int unsigned m_tag   [D];
    int          m_ctr   [D];
    logic [31:0] m_tgt   [D];
    int unsigned m_ghr;

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return (pc >> (IB + 2)) % (1 << TB);
    endfunction

    function automatic int unsigned m_index(input logic [31:0] pc);
`ifdef BP_GSHARE_EN
        return ((pc >> 2) % D) ^ m_ghr;
`else
        return (pc >> 2) % D;
`endif
    endfunction

    task automatic model_reset();
        for (int d = 0; d < D; d++) begin
            m_valid[d] = 0; m_tag[d] = 0; m_ctr[d] = 1; m_tgt[d] = '0;
        end
        m_ghr = 0;
    endtask

    task automatic model_clock();
        int unsigned ix [UW];
        bit          win;
        for (int p = 0; p < UW; p++) ix[p] = m_index(update_pc[p]);
        if (flush_EN) begin
            for (int d = 0; d < D; d++) m_valid[d] = 0;
            m_ghr = 0;
            return;
        end
        for (int p = 0; p < UW; p++) begin
            win = update_EN[p];
            for (int q = p + 1; q < UW; q++)
                if (update_EN[q] && ix[q] == ix[p]) win = 0;
            if (win) begin
                if (m_valid[ix[p]] && m_tag[ix[p]] == tag_of(update_pc[p])) begin
                    if (update_direction[p]) begin
                        m_ctr[ix[p]] = (m_ctr[ix[p]] == 3) ? 3 : m_ctr[ix[p]] + 1;
                        m_tgt[ix[p]] = update_target[p];
                    end else begin
                        m_ctr[ix[p]] = (m_ctr[ix[p]] == 0) ? 0 : m_ctr[ix[p]] - 1;
                    end
                end else if (update_direction[p]) begin
                    m_valid[ix[p]] = 1;
                    m_tag[ix[p]]   = tag_of(update_pc[p]);
                    m_ctr[ix[p]]   = 2;
                    m_tgt[ix[p]]   = update_target[p];
                end
            end
        end
        for (int p = 0; p < UW; p++)
            if (update_EN[p]) m_ghr = ((m_ghr << 1) | int'(update_direction[p])) % D;
    endtask

    task automatic check_outputs(input string tag);
        bit          ed;
        logic [31:0] ep;
        int          first;
        int unsigned i;
        first = -1;
        for (int l = 0; l < FW; l++) begin
            i  = m_index(fetch_pc[l]);
            ed = fetch_EN[l] && m_valid[i] && (m_tag[i] == tag_of(fetch_pc[l])) && (m_ctr[i] >= 2);
            ep = ed ? m_tgt[i] : fetch_pc[l] + 32'd4;
            check($sformatf("%s_dir%0d", tag, l), 64'(predict_direction[l]), 64'(ed));
            check($sformatf("%s_pc%0d", tag, l), 64'(predict_pc[l]), 64'(ep));
            if (ed && first < 0) first = l;
        end
        check($sformatf("%s_any", tag), 64'(taken_any), 64'(first >= 0));
        check($sformatf("%s_idx", tag), 64'(taken_idx), 64'((first < 0) ? 0 : first));
    endtask

    task automatic cycle(input string tag);
        @(negedge clock);
        check_outputs(tag);
        model_clock();
        @(posedge clock);
        #1;
    endtask

    task automatic set_fetch(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        fetch_EN = '1;
        fetch_pc[0] = a; fetch_pc[1] = b; fetch_pc[2] = c;
    endtask

    task automatic set_upd(input int p, input logic [31:0] pc, input logic dir, input logic [31:0] tgt);
        update_EN[p] = 1'b1; update_pc[p] = pc;
        update_direction[p] = dir; update_target[p] = tgt;
    endtask

    task automatic clear_upd();
        update_EN = '0; update_pc = '0; update_direction = '0; update_target = '0;
        flush_EN = 1'b0;
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
        if ($urandom_range(0, 7) == 0) p = p | ($urandom() & 32'hFFFF_C003);
        return p;
    endfunction

    task automatic async_reset_pulse(input string tag);
        @(negedge clock);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_outputs(tag);
        @(posedge clock);
        #1;
        check_outputs({tag, "_hold"});
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b0;
        fetch_EN = '0; fetch_pc = '0;
        clear_upd();
        model_reset();
        set_fetch(32'd4, 32'd8, 32'd12);
        repeat (2) @(posedge clock);
        #1;
        check_outputs("rst");
        reset = 1'b1;

        // Cold table: everything falls through to pc+4.
        #1;
        check("t1_dir", 64'(predict_direction), 64'(0));
        check("t1_pc0", 64'(predict_pc[0]), 64'(8));
        check("t1_pc1", 64'(predict_pc[1]), 64'(12));
        check("t1_pc2", 64'(predict_pc[2]), 64'(16));
        check("t1_any", 64'(taken_any), 64'(0));
        cycle("t1");

        set_upd(0, 32'd4, 1'b1, 32'd80);
        cycle("t2a");
        clear_upd();
        #1;
        check("t2_dir0", 64'(predict_direction[0]), 64'(1));
        check("t2_pc0", 64'(predict_pc[0]), 64'(80));
        check("t2_any", 64'(taken_any), 64'(1));
        check("t2_idx", 64'(taken_idx), 64'(0));
        cycle("t2b");
        fetch_pc[0] = 32'd68;
        #1;
        check("t2_miss_dir", 64'(predict_direction[0]), 64'(0));
        check("t2_miss_pc", 64'(predict_pc[0]), 64'(72));
        cycle("t2c");

        set_fetch(32'd4, 32'd8, 32'd12);
        set_upd(0, 32'd4, 1'b1, 32'd80);
        repeat (3) cycle("t3t");
        set_upd(0, 32'd4, 1'b0, 32'd0);
        cycle("t3n");
        clear_upd();
        #1;
        check("t3_still_taken", 64'(predict_direction[0]), 64'(1));
        set_upd(0, 32'd4, 1'b0, 32'd0);
        repeat (2) cycle("t3nn");
        clear_upd();
        #1;
        check("t3_dir0", 64'(predict_direction[0]), 64'(0));
        check("t3_pc0", 64'(predict_pc[0]), 64'(8));
        cycle("t3e");

        set_upd(0, 32'd4, 1'b1, 32'd80);
        set_upd(1, 32'd68, 1'b1, 32'd200);
        cycle("t4a");
        clear_upd();
        set_fetch(32'd68, 32'd4, 32'd12);
        #1;
        check("t4_pc68", 64'(predict_pc[0]), 64'(200));
        check("t4_dir68", 64'(predict_direction[0]), 64'(1));
        check("t4_pc4", 64'(predict_pc[1]), 64'(8));
        check("t4_dir4", 64'(predict_direction[1]), 64'(0));
        cycle("t4b");

        set_upd(0, 32'd8, 1'b1, 32'd40);
        cycle("t5a");
        set_upd(0, 32'd12, 1'b1, 32'd99);
        flush_EN = 1'b1;
        cycle("t5b");
        clear_upd();
        set_fetch(32'd8, 32'd12, 32'd4);
        #1;
        check("t5_dir8", 64'(predict_direction[0]), 64'(0));
        check("t5_pc8", 64'(predict_pc[0]), 64'(12));
        check("t5_dir12", 64'(predict_direction[1]), 64'(0));
        check("t5_pc12", 64'(predict_pc[1]), 64'(16));
        cycle("t5c");

        set_upd(0, 32'd4, 1'b1, 32'd80);
        set_upd(1, 32'd8, 1'b1, 32'd40);
        cycle("t6a");
        clear_upd();
        set_fetch(32'd4, 32'd8, 32'd12);
        #1;
        check("t6_pre_any", 64'(taken_any), 64'(1));
        async_reset_pulse("t6rst");
        #1;
        check("t6_dir", 64'(predict_direction), 64'(0));
        check("t6_pc0", 64'(predict_pc[0]), 64'(8));
        check("t6_pc1", 64'(predict_pc[1]), 64'(12));
        cycle("t6b");

        for (int n = 0; n < 1500; n++) begin
            fetch_EN = FW'($urandom());
            for (int l = 0; l < FW; l++) fetch_pc[l] = rand_pc();
            update_EN = UW'($urandom());
            for (int p = 0; p < UW; p++) begin
                update_pc[p] = rand_pc();
                update_direction[p] = ($urandom_range(0, 2) != 0);
                update_target[p] = $urandom() & 32'hFFFF_FFFC;
            end
            flush_EN = ($urandom_range(0, 39) == 0);
            cycle("rnd");
            if (n == 800) begin
                clear_upd();
                async_reset_pulse("rnd_rst");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
